// File: rtl/approx_mac_accum.sv
// Saturating dot-product accumulator for the approximate multiplier's product stream.
// Optional per-beat bias compensation is enabled with the APPROX_BIAS_COMP_EN macro.
module approx_mac_accum #(
    parameter int unsigned ACC_W    = 24,
    parameter int unsigned MAX_LEN  = 255,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned COMP_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, out_sum_q, out_sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, out_cnt_q, out_cnt_d;
    logic             ovf_q, ovf_d, out_ovf_q, out_ovf_d;

    logic             accept, fresh, carry, beat_ovf, beat_last;
    logic [ACC_W-1:0] term, base, beat_acc;
    logic [ACC_W:0]   raw_sum;
    logic [CNT_W-1:0] beat_cnt;

    if (ACC_W < 16 || MAX_LEN == 0 || (64'(MAX_LEN) >> CNT_W) != 0 ||
        (64'(COMP_VAL) >> ACC_W) != 0) begin : g_param_check
        $error("approx_mac_accum: illegal parameter combination");
    end

`ifdef APPROX_BIAS_COMP_EN
    assign term = ACC_W'(in_prod) + ACC_W'(COMP_VAL);
`else
    assign term = ACC_W'(in_prod);
`endif

    // A beat outside ACCUM always opens a new vector; in HOLD it can only arrive
    // together with the consumer taking the pending result.
    assign fresh     = (state_q != ACCUM);
    assign base      = fresh ? '0 : acc_q;
    assign raw_sum   = {1'b0, base} + {1'b0, term};
    assign carry     = raw_sum[ACC_W];
    assign beat_acc  = carry ? '1 : raw_sum[ACC_W-1:0];
    assign beat_ovf  = carry | (~fresh & ovf_q);
    assign beat_cnt  = fresh ? CNT_W'(1) : cnt_q + 1'b1;
    assign beat_last = in_last | (beat_cnt == CNT_W'(MAX_LEN));

    assign in_ready  = (state_q == HOLD) ? out_ready : 1'b1;
    assign accept    = in_valid & in_ready;

    assign out_valid = (state_q == HOLD);
    assign out_sum   = out_sum_q;
    assign out_cnt   = out_cnt_q;
    assign out_ovf   = out_ovf_q;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        out_sum_d = out_sum_q;
        out_cnt_d = out_cnt_q;
        out_ovf_d = out_ovf_q;

        if (state_q == HOLD && out_ready && !accept) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end

        if (accept) begin
            acc_d = beat_acc;
            cnt_d = beat_cnt;
            ovf_d = beat_ovf;
            if (beat_last) begin
                state_d   = HOLD;
                out_sum_d = beat_acc;
                out_cnt_d = beat_cnt;
                out_ovf_d = beat_ovf;
            end else begin
                state_d = ACCUM;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_sum_q <= '0;
            out_cnt_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            out_sum_q <= out_sum_d;
            out_cnt_q <= out_cnt_d;
            out_ovf_q <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_approx_mac_accum.sv
// Self-checking bench for approx_mac_accum: vector table, corner sequences, and a
// randomized run against a vector-level reference model.
`timescale 1ns/1ps
module tb_approx_mac_accum;

    localparam int ACC_W    = 16;
    localparam int MAX_LEN  = 4;
    localparam int CNT_W    = 8;
    localparam int COMP_VAL = 3;
`ifdef APPROX_BIAS_COMP_EN
    localparam int COMP = COMP_VAL;
`else
    localparam int COMP = 0;
`endif
    localparam int ACC_MAX = (1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      in_prod = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_cnt;
    logic             out_ovf;

    int total = 0;
    int bad = 0;

    typedef struct {
        string nm;
        bit    v;
        int    p;
        bit    l;
        bit    r;
        bit    ev;
        int    es;
        int    ec;
        bit    eo;
        bit    er;
    } vec_t;

    vec_t tbl[$];

    approx_mac_accum #(
        .ACC_W(ACC_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .COMP_VAL(COMP_VAL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cnt(out_cnt), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    // Per-beat term as the accumulator sees it, wrapped to the accumulator width.
    function automatic int tt(input int p);
        return (p + COMP) & ACC_MAX;
    endfunction

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic checkResult(input string nm, input bit ev, input int es, input int ec, input bit eo);
        checkOutput({nm, "_valid"}, 32'(out_valid), 32'(ev));
        if (ev) begin
            checkOutput({nm, "_sum"}, 32'(out_sum), es);
            checkOutput({nm, "_cnt"}, 32'(out_cnt), ec);
            checkOutput({nm, "_ovf"}, 32'(out_ovf), 32'(eo));
        end
    endtask

    task automatic applyStimulus(input bit v, input int p, input bit l, input bit r);
        in_valid  = v;
        in_prod   = 16'(p);
        in_last   = l;
        out_ready = r;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic addRow(input string nm, input bit v, input int p, input bit l, input bit r,
                          input bit ev, input int es, input int ec, input bit eo, input bit er);
        vec_t e;
        e.nm = nm; e.v = v; e.p = p; e.l = l; e.r = r;
        e.ev = ev; e.es = es; e.ec = ec; e.eo = eo; e.er = er;
        tbl.push_back(e);
    endtask

    int  satSum;
    bit  satOvf;
    int  vsum, vcnt, msum, mcnt;
    bit  vovf, mvalid, movf;
    bit  rv, rl, rr, expRdy;
    int  rp;

    initial begin
        // Reset state, sampled while reset is held.
        #2;
        checkResult("reset", 1'b0, 0, 0, 1'b0);
        checkOutput("reset_sum", 32'(out_sum), 0);
        checkOutput("reset_cnt", 32'(out_cnt), 0);
        checkOutput("reset_ovf", 32'(out_ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_in_ready", 32'(in_ready), 1);
        @(negedge clk);

        satSum = tt(16'hFFFF) + tt(2);
        satOvf = (satSum > ACC_MAX);
        if (satOvf) satSum = ACC_MAX;

        addRow("basic1", 1, 100, 0, 1, 0, 0, 0, 0, 1);
        addRow("basic2", 1, 200, 0, 1, 0, 0, 0, 0, 1);
        addRow("basic3", 1, 300, 1, 1, 1, tt(100) + tt(200) + tt(300), 3, 0, 1);
        addRow("basic4", 0, 0, 0, 1, 0, 0, 0, 0, 1);
        addRow("bp1", 1, 16'hFFFF, 1, 0, 1, tt(16'hFFFF), 1, 0, 0);
        for (int i = 0; i < 4; i++)
            addRow("bp_hold", 1, 123, 1, 0, 1, tt(16'hFFFF), 1, 0, 0);
        addRow("bp_release", 0, 0, 0, 1, 0, 0, 0, 0, 1);
        addRow("sat1", 1, 16'hFFFF, 0, 1, 0, 0, 0, 0, 1);
        addRow("sat2", 1, 2, 1, 1, 1, satSum, 2, satOvf, 1);
        addRow("sat_next", 1, 5, 1, 1, 1, tt(5), 1, 0, 1);
        addRow("sat_drain", 0, 0, 0, 1, 0, 0, 0, 0, 1);

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].v, tbl[i].p, tbl[i].l, tbl[i].r);
            step();
            checkResult(tbl[i].nm, tbl[i].ev, tbl[i].es, tbl[i].ec, tbl[i].eo);
            checkOutput({tbl[i].nm, "_in_ready"}, 32'(in_ready), 32'(tbl[i].er));
        end

        // Forced last: eight unit beats with in_last never asserted.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 1, 0, 1);
            step();
            checkResult("forced_last", (i == 3) || (i == 7), 4 * tt(1), 4, 1'b0);
        end
        applyStimulus(0, 0, 0, 1);
        step();

        // Result consumed and a new single-beat vector accepted on the same edge.
        applyStimulus(1, 10, 1, 0);
        step();
        checkResult("simul_hold", 1'b1, tt(10), 1, 1'b0);
        checkOutput("simul_hold_in_ready", 32'(in_ready), 0);
        applyStimulus(1, 7, 1, 1);
        #1;
        checkOutput("simul_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        step();
        checkResult("simul_new", 1'b1, tt(7), 1, 1'b0);
        applyStimulus(0, 0, 0, 1);
        step();
        checkResult("simul_drain", 1'b0, 0, 0, 1'b0);

        // Asynchronous reset in the middle of a vector.
        applyStimulus(1, 50, 0, 1);
        step();
        applyStimulus(1, 60, 0, 1);
        step();
        applyStimulus(0, 0, 0, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_valid", 32'(out_valid), 0);
        checkOutput("rst_mid_sum", 32'(out_sum), 0);
        checkOutput("rst_mid_cnt", 32'(out_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_mid_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        applyStimulus(1, 9, 1, 1);
        step();
        checkResult("rst_mid_after", 1'b1, tt(9), 1, 1'b0);
        applyStimulus(0, 0, 0, 1);
        step();

        // Randomized traffic against the vector-level model.
        mvalid = 0; msum = 0; mcnt = 0; movf = 0;
        vsum = 0; vcnt = 0; vovf = 0;
        for (int c = 0; c < 400; c++) begin
            rv = ($urandom_range(0, 3) != 0);
            rp = $urandom_range(0, 1) ? int'($urandom_range(60000, 65535)) : int'($urandom_range(0, 65535));
            rl = ($urandom_range(0, 4) == 0);
            rr = ($urandom_range(0, 2) != 0);
            applyStimulus(rv, rp, rl, rr);
            #1;
            expRdy = !mvalid || rr;
            checkOutput("rand_in_ready", 32'(in_ready), 32'(expRdy));
            if (mvalid && rr) mvalid = 0;
            if (rv && expRdy) begin
                vsum += tt(rp);
                vcnt++;
                if (vsum > ACC_MAX) begin
                    vsum = ACC_MAX;
                    vovf = 1;
                end
                if (rl || vcnt == MAX_LEN) begin
                    mvalid = 1; msum = vsum; mcnt = vcnt; movf = vovf;
                    vsum = 0; vcnt = 0; vovf = 0;
                end
            end
            @(negedge clk);
            checkResult("rand", mvalid, msum, mcnt, movf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
